// File: rtl/led_pattern_sched.sv
// Push-button front end (2-FF sync + debounce) and four-mode LED pattern sequencer.
// KEY[0] steps the display mode, KEY[1] pauses or resumes the animation.
module led_pattern_sched #(
    parameter int unsigned TICK_DIV   = 12_500_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [1:0] KEY,
    output logic [7:0] LED,
    output logic [1:0] MODE,
    output logic       RUN
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DebW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
    localparam logic [DebW-1:0]  DebMax  = DebW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ModeCount = 2'd0,
        ModeScan  = 2'd1,
        ModeBlink = 2'd2,
        ModeFill  = 2'd3
    } mode_e;

    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            key_s;
    logic [1:0]            deb_q, deb_d;
    logic [1:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [1:0]            press;
    logic [TickW-1:0]      tick_q;
    mode_e                 mode_q, mode_next;
    logic [7:0]            led_q, led_step, led_start;
    logic                  run_q;
    logic                  down_q, down_step;

    assign key_s = ~sync2_q;

    // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (key_s[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DebMax) begin
                deb_d[i]     = key_s[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
            end
        end
    end

    assign press = deb_d & ~deb_q;

    always_comb begin
        led_step  = led_q;
        down_step = down_q;
        unique case (mode_q)
            ModeCount: led_step = led_q + 8'd1;
            ModeScan: begin
                led_step = down_q ? (led_q >> 1) : (led_q << 1);
                if (led_step == 8'h80) begin
                    down_step = 1'b1;
                end else if (led_step == 8'h01) begin
                    down_step = 1'b0;
                end
            end
            ModeBlink: led_step = ~led_q;
            ModeFill:  led_step = (led_q == 8'hFF) ? 8'h00 : {led_q[6:0], 1'b1};
            default:   led_step = led_q;
        endcase
    end

    always_comb begin
        mode_next = mode_e'(mode_q + 2'd1);
        led_start = (mode_next == ModeScan) ? 8'h01 : 8'h00;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            deb_q     <= 2'b00;
            deb_cnt_q <= '0;
            tick_q    <= '0;
            mode_q    <= ModeCount;
            led_q     <= 8'h00;
            run_q     <= 1'b1;
            down_q    <= 1'b0;
        end else begin
            sync1_q   <= KEY;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            // A mode change overrides any tick landing on the same edge.
            if (press[0]) begin
                mode_q <= mode_next;
                led_q  <= led_start;
                tick_q <= '0;
                down_q <= 1'b0;
            end else if (run_q) begin
                if (tick_q == TickMax) begin
                    tick_q <= '0;
                    led_q  <= led_step;
                    down_q <= down_step;
                end else begin
                    tick_q <= tick_q + TickW'(1);
                end
            end
            if (press[1]) begin
                run_q <= ~run_q;
            end
        end
    end

    assign LED  = led_q;
    assign MODE = mode_q;
    assign RUN  = run_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed bench for led_pattern_sched with TICK_DIV=4, DEB_CYCLES=3; expected outputs
// are queued as stimulus is applied and checked when the DUT should have produced them.
module tb_led_pattern_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key;
    logic [7:0] led;
    logic [1:0] mode;
    logic       run;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_led_q  [$];
    logic [1:0] exp_mode_q [$];
    logic       exp_run_q  [$];

    logic [7:0] scan_seq [13] = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20,
                                  8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fill_seq [9]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                  8'hFF, 8'h00};

    led_pattern_sched #(
        .TICK_DIV   (4),
        .DEB_CYCLES (3)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .KEY      (key),
        .LED      (led),
        .MODE     (mode),
        .RUN      (run)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [7:0] l, input logic [1:0] m, input logic r);
        exp_led_q.push_back(l);
        exp_mode_q.push_back(m);
        exp_run_q.push_back(r);
    endtask

    task automatic compare_out(input string tag);
        if (exp_led_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
        end else begin
            check({tag, "_led"}, led, exp_led_q.pop_front());
            check({tag, "_mode"}, {6'b0, mode}, {6'b0, exp_mode_q.pop_front()});
            check({tag, "_run"}, {7'b0, run}, {7'b0, exp_run_q.pop_front()});
        end
    endtask

    // Four low samples then release: the press is accepted on the fifth edge.
    task automatic press(input logic [1:0] mask);
        key = ~mask;
        tick(4);
        key = 2'b11;
        tick(1);
    endtask

    initial begin
        rst = 1'b1;
        key = 2'b11;
        expect_out(8'h00, 2'd0, 1'b1);
        tick(2);
        compare_out("reset");
        rst = 1'b0;

        // COUNT from reset
        expect_out(8'h00, 2'd0, 1'b1);
        tick(3);
        compare_out("count_hold");
        for (int i = 1; i <= 10; i++) expect_out(8'(i), 2'd0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick(4);
            compare_out("count_step");
        end
        expect_out(8'hFF, 2'd0, 1'b1);
        tick(980);
        compare_out("count_ff");
        expect_out(8'h00, 2'd0, 1'b1);
        tick(4);
        compare_out("count_wrap");

        // KEY[0] held low for 10 cycles: event on edge 5
        key[0] = 1'b0;
        tick(4);
        check("deb_early_mode", {6'b0, mode}, 8'd0);
        expect_out(8'h01, 2'd1, 1'b1);
        tick(1);
        compare_out("scan_enter");
        expect_out(8'h02, 2'd1, 1'b1);
        tick(4);
        compare_out("scan_02");
        tick(1);
        key[0] = 1'b1;
        expect_out(8'h04, 2'd1, 1'b1);
        tick(3);
        compare_out("scan_04");
        foreach (scan_seq[i]) expect_out(scan_seq[i], 2'd1, 1'b1);
        foreach (scan_seq[i]) begin
            tick(4);
            compare_out("scan_seq");
        end

        // Short bounces never reach the debounce threshold
        expect_out(8'h40, 2'd1, 1'b1);
        repeat (5) begin
            key[0] = 1'b0;
            tick(2);
            key[0] = 1'b1;
            tick(1);
        end
        tick(5);
        compare_out("glitch_none");

        // BLINK, FILL, wrap back to COUNT
        expect_out(8'h00, 2'd2, 1'b1);
        press(2'b01);
        compare_out("blink_enter");
        expect_out(8'hFF, 2'd2, 1'b1);
        expect_out(8'h00, 2'd2, 1'b1);
        tick(4);
        compare_out("blink_ff");
        tick(4);
        compare_out("blink_00");
        expect_out(8'h00, 2'd3, 1'b1);
        press(2'b01);
        compare_out("fill_enter");
        foreach (fill_seq[i]) expect_out(fill_seq[i], 2'd3, 1'b1);
        foreach (fill_seq[i]) begin
            tick(4);
            compare_out("fill_seq");
        end
        expect_out(8'h00, 2'd0, 1'b1);
        press(2'b01);
        compare_out("mode_wrap");

        // Pause at 0x05, mode change while paused, resume
        expect_out(8'h04, 2'd0, 1'b1);
        tick(16);
        compare_out("count_04");
        expect_out(8'h05, 2'd0, 1'b0);
        press(2'b10);
        compare_out("pause");
        expect_out(8'h05, 2'd0, 1'b0);
        tick(50);
        compare_out("pause_hold");
        expect_out(8'h01, 2'd1, 1'b0);
        press(2'b01);
        compare_out("paused_mode");
        expect_out(8'h01, 2'd1, 1'b0);
        tick(20);
        compare_out("paused_scan_hold");
        expect_out(8'h01, 2'd1, 1'b1);
        press(2'b10);
        compare_out("resume");
        expect_out(8'h01, 2'd1, 1'b1);
        tick(3);
        compare_out("resume_wait");
        expect_out(8'h02, 2'd1, 1'b1);
        tick(1);
        compare_out("resume_step");

        // Both keys on the same edge
        expect_out(8'h00, 2'd2, 1'b0);
        press(2'b11);
        compare_out("both_keys");
        expect_out(8'h00, 2'd2, 1'b0);
        tick(8);
        compare_out("both_paused_hold");
        expect_out(8'h00, 2'd2, 1'b1);
        press(2'b10);
        compare_out("both_resume");
        expect_out(8'h00, 2'd2, 1'b1);
        tick(3);
        compare_out("blink_wait");
        expect_out(8'hFF, 2'd2, 1'b1);
        tick(1);
        compare_out("blink_resume_step");

        // Back to SCAN, then reset mid-debounce and mid-scan
        expect_out(8'h00, 2'd3, 1'b1);
        press(2'b01);
        compare_out("to_fill");
        tick(4);
        expect_out(8'h00, 2'd0, 1'b1);
        press(2'b01);
        compare_out("to_count");
        tick(4);
        expect_out(8'h01, 2'd1, 1'b1);
        press(2'b01);
        compare_out("to_scan");
        expect_out(8'h02, 2'd1, 1'b1);
        tick(4);
        compare_out("scan_before_reset");
        key[0] = 1'b0;
        tick(3);
        rst = 1'b1;
        expect_out(8'h00, 2'd0, 1'b1);
        tick(1);
        compare_out("reset_mid");
        rst = 1'b0;
        expect_out(8'h01, 2'd0, 1'b1);
        tick(4);
        compare_out("reset_no_event");
        expect_out(8'h01, 2'd1, 1'b1);
        tick(1);
        compare_out("post_reset_press");
        key[0] = 1'b1;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
